id_ex_register: RTL



---
 rtl/id_ex_register.sv | 104 ++++++++++
 1 files changed

// File: rtl/id_ex_register.sv
// Decode-to-execute pipeline register with stall, flush and valid tracking,
// plus bubble and stall-cycle performance counters.
module id_ex_register #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enE,
  input  logic             flushE,
  input  logic             validD,
  input  logic             reg_writeD,
  input  logic             alu_srcD,
  input  logic             mem_writeD,
  input  logic             branchD,
  input  logic             jumpD,
  input  logic [1:0]       result_srcD,
  input  logic [2:0]       alu_controlD,
  input  logic [XLEN-1:0]  rd1D,
  input  logic [XLEN-1:0]  rd2D,
  input  logic [XLEN-1:0]  pcD,
  input  logic [XLEN-1:0]  pc_plus4D,
  input  logic [XLEN-1:0]  imm_extD,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rdD,
  output logic             validE,
  output logic             reg_writeE,
  output logic             alu_srcE,
  output logic             mem_writeE,
  output logic             branchE,
  output logic             jumpE,
  output logic [1:0]       result_srcE,
  output logic [2:0]       alu_controlE,
  output logic [XLEN-1:0]  rd1E,
  output logic [XLEN-1:0]  rd2E,
  output logic [XLEN-1:0]  pcE,
  output logic [XLEN-1:0]  pc_plus4E,
  output logic [XLEN-1:0]  imm_extE,
  output logic [4:0]       rs1E,
  output logic [4:0]       rs2E,
  output logic [4:0]       rdE,
  output logic [CNT_W-1:0] bubble_cntE,
  output logic [CNT_W-1:0] stall_cntE
);

  // Control fields are gated with validD so an invalid slot behaves like a bubble.
  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      validE       <= 1'b0;
      reg_writeE   <= 1'b0;
      alu_srcE     <= 1'b0;
      mem_writeE   <= 1'b0;
      branchE      <= 1'b0;
      jumpE        <= 1'b0;
      result_srcE  <= 2'b00;
      alu_controlE <= 3'b000;
    end else if (enE) begin
      validE       <= validD;
      reg_writeE   <= reg_writeD & validD;
      alu_srcE     <= alu_srcD & validD;
      mem_writeE   <= mem_writeD & validD;
      branchE      <= branchD & validD;
      jumpE        <= jumpD & validD;
      result_srcE  <= result_srcD & {2{validD}};
      alu_controlE <= alu_controlD & {3{validD}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flushE) begin
      rd1E      <= '0;
      rd2E      <= '0;
      pcE       <= '0;
      pc_plus4E <= '0;
      imm_extE  <= '0;
      rs1E      <= 5'd0;
      rs2E      <= 5'd0;
      rdE       <= 5'd0;
    end else if (enE) begin
      rd1E      <= rd1D;
      rd2E      <= rd2D;
      pcE       <= pcD;
      pc_plus4E <= pc_plus4D;
      imm_extE  <= imm_extD;
      rs1E      <= rs1D;
      rs2E      <= rs2D;
      rdE       <= rdD;
    end
  end

  // Flush outranks stall, so a cycle with both counts only as a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      bubble_cntE <= '0;
      stall_cntE  <= '0;
    end else if (flushE) begin
      bubble_cntE <= bubble_cntE + CNT_W'(1);
    end else if (!enE) begin
      stall_cntE  <= stall_cntE + CNT_W'(1);
    end
  end

endmodule
